// File: rtl/swo_manch_tx.sv
// Manchester SWO transmitter: start bit, back-to-back LSB-first bytes, idle-low closing gap.
// Half-bit length is captured at packet start so a packet never changes rate midway.
module swo_manch_tx #(
   parameter int CNT_W    = 16,
   parameter int GAP_BITS = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] halfbitlen,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             SWOout,
   output logic             busy,
   output logic             byteSent
);
   localparam int GAP_W = CNT_W + $clog2(2 * GAP_BITS) + 1;

   typedef enum logic [2:0] {IDLE, START_H, START_L, DATA1, DATA2, GAP} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] hb_reg, hb_next;
   logic [CNT_W-1:0] tick_reg, tick_next;
   logic [GAP_W-1:0] gap_reg, gap_next;
   logic [GAP_W-1:0] gap_len;
   logic [7:0]       shift_reg, shift_next;
   logic [7:0]       hold_reg;
   logic [2:0]       bit_reg, bit_next;
   logic             hold_full_reg;
   logic             byte_sent_reg, byte_sent_next;
   logic             take, accept, half_end, gap_end;

   assign accept   = in_valid && !hold_full_reg;
   assign half_end = (tick_reg == hb_reg - CNT_W'(1));
   assign gap_len  = GAP_W'(2 * GAP_BITS) * GAP_W'(hb_reg);
   assign gap_end  = (gap_reg == gap_len - GAP_W'(1));

   assign in_ready = !hold_full_reg;
   assign busy     = (state_reg != IDLE);
   assign byteSent = byte_sent_reg;

   // Line level is a pure function of registered state so reset pulls it low at once.
   always_comb begin
      SWOout = 1'b0;
      case (state_reg)
         START_H: SWOout = 1'b1;
         DATA1:   SWOout = shift_reg[0];
         DATA2:   SWOout = ~shift_reg[0];
         default: SWOout = 1'b0;
      endcase
   end

   always_comb begin
      state_next     = state_reg;
      hb_next        = hb_reg;
      tick_next      = half_end ? '0 : tick_reg + CNT_W'(1);
      gap_next       = gap_reg;
      shift_next     = shift_reg;
      bit_next       = bit_reg;
      byte_sent_next = byte_sent_reg;
      take           = 1'b0;
      case (state_reg)
         IDLE: begin
            tick_next = '0;
            gap_next  = '0;
            if (hold_full_reg) begin
               take       = 1'b1;
               hb_next    = (halfbitlen == '0) ? CNT_W'(1) : halfbitlen;
               shift_next = hold_reg;
               bit_next   = 3'd0;
               state_next = START_H;
            end
         end
         START_H: begin
            if (half_end) state_next = START_L;
         end
         START_L: begin
            if (half_end) state_next = DATA1;
         end
         DATA1: begin
            if (half_end) state_next = DATA2;
         end
         DATA2: begin
            if (half_end) begin
               if (bit_reg == 3'd7) begin
                  byte_sent_next = ~byte_sent_reg;
                  // A waiting byte continues the packet without a new start bit.
                  if (hold_full_reg) begin
                     take       = 1'b1;
                     shift_next = hold_reg;
                     bit_next   = 3'd0;
                     state_next = DATA1;
                  end else begin
                     gap_next   = '0;
                     state_next = GAP;
                  end
               end else begin
                  bit_next   = bit_reg + 3'd1;
                  shift_next = {1'b0, shift_reg[7:1]};
                  state_next = DATA1;
               end
            end
         end
         GAP: begin
            tick_next = '0;
            if (gap_end) state_next = IDLE;
            else         gap_next   = gap_reg + GAP_W'(1);
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         hb_reg        <= CNT_W'(1);
         tick_reg      <= '0;
         gap_reg       <= '0;
         shift_reg     <= '0;
         bit_reg       <= '0;
         byte_sent_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         hb_reg        <= hb_next;
         tick_reg      <= tick_next;
         gap_reg       <= gap_next;
         shift_reg     <= shift_next;
         bit_reg       <= bit_next;
         byte_sent_reg <= byte_sent_next;
      end
   end

   // Holding register: an accept on the same edge as a take keeps it full with the new byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
      end else begin
         if (accept) hold_reg <= in_data;
         hold_full_reg <= accept | (hold_full_reg & ~take);
      end
   end

endmodule

// File: tb/tb_swo_manch_tx.sv
// Bench for swo_manch_tx: per-cycle line/busy/byteSent check against a waveform model
// built from the byte list, half-bit length and gap length.
module tb_swo_manch_tx;
   localparam int CNT_W    = 16;
   localparam int GAP_BITS = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [CNT_W-1:0] halfbitlen = 16'd4;
   logic [7:0]       in_data = 8'h00;
   logic             in_valid = 1'b0;
   logic             in_ready, SWOout, busy, byteSent;

   int   total = 0;
   int   bad = 0;
   logic model_bs = 1'b0;
   logic [7:0] burst_q[$];

   swo_manch_tx #(.CNT_W(CNT_W), .GAP_BITS(GAP_BITS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .halfbitlen (halfbitlen),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .SWOout     (SWOout),
      .busy       (busy),
      .byteSent   (byteSent)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected line level n cycles after packet start for the bytes in burst_q.
   function automatic logic exp_line(input int n, input int hb);
      int d, k, r;
      logic [7:0] byte_v;
      logic b;
      if (n < hb) return 1'b1;
      if (n < 2 * hb) return 1'b0;
      d = n - 2 * hb;
      if (d >= 16 * hb * burst_q.size()) return 1'b0;
      k = d / (16 * hb);
      r = d % (16 * hb);
      byte_v = burst_q[k];
      b = byte_v[r / (2 * hb)];
      return ((r % (2 * hb)) < hb) ? b : ~b;
   endfunction

   // Offer burst_q back-to-back and check every cycle of the resulting packet.
   task automatic run_burst(input int hbl, input int chg_at, input int chg_val);
      int hb, nb, plen, n, idx, first_acc, toggles;
      logic rdy, done;
      logic [2:0] exp_v;
      hb = (hbl == 0) ? 1 : hbl;
      nb = burst_q.size();
      plen = 2 * hb + 16 * hb * nb + 2 * GAP_BITS * hb;
      n = -1; idx = 0; first_acc = -1; done = 1'b0;
      halfbitlen = CNT_W'(hbl);
      for (int cyc = 0; cyc < plen + 64 && !done; cyc++) begin
         rdy = in_ready;
         in_valid = (idx < nb);
         in_data = (idx < nb) ? burst_q[idx] : 8'h00;
         @(posedge clk);
         if (in_valid && rdy) begin
            if (idx == 0) first_acc = cyc;
            if (idx == 1) check("accept_gap", cyc - first_acc, 2);
            idx++;
         end
         @(negedge clk);
         if (n < 0 && busy) n = 0;
         if (n >= 0) begin
            toggles = 0;
            for (int k = 0; k < nb; k++)
               if (n >= 2 * hb + 16 * hb * (k + 1)) toggles++;
            exp_v = {exp_line(n, hb), (n < plen), model_bs ^ toggles[0]};
            check($sformatf("swo_busy_sent n=%0d hb=%0d", n, hb),
                  {29'd0, SWOout, busy, byteSent}, {29'd0, exp_v});
            if (n == chg_at) halfbitlen = CNT_W'(chg_val);
            if (n == plen) done = 1'b1;
            n++;
         end
      end
      in_valid = 1'b0;
      if (!done) check("packet_timeout", 0, 1);
      check("bytes_taken", idx, nb);
      model_bs = model_bs ^ nb[0];
   endtask

   initial begin
      int sent, len, hbl, waited;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_swo", SWOout, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", in_ready, 1);
      check("rst_sent", byteSent, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", busy, 0);

      // 0xA5 at hb=4
      burst_q = '{8'hA5};
      run_burst(4, -1, 0);

      // Two back-to-back bytes at hb=3 share one start bit and one gap
      burst_q = '{8'h01, 8'h80};
      run_burst(3, -1, 0);

      // halfbitlen=0 behaves as 1
      burst_q = '{8'h00};
      run_burst(0, -1, 0);

      // Rate change mid-byte is ignored until the next packet
      burst_q = '{8'h3C};
      run_burst(4, 30, 8);
      check("hbl_changed", halfbitlen, 8);
      burst_q = '{8'h5A};
      run_burst(8, -1, 0);

      // Reset during bit 3 of 0xFF
      burst_q = '{8'hFF};
      halfbitlen = 16'd4;
      in_data = 8'hFF;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      waited = 0;
      while (!busy && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      check("abort_start_busy", busy, 1);
      repeat (34) @(negedge clk);
      check("abort_pre_swo", SWOout, exp_line(34, 4));
      #2 rst_n = 1'b0;
      #1;
      check("abort_swo", SWOout, 0);
      check("abort_busy", busy, 0);
      check("abort_ready", in_ready, 1);
      check("abort_sent", byteSent, 0);
      model_bs = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      burst_q = '{8'h96};
      run_burst(4, -1, 0);

      // 256 random bytes in bursts of 1..4 at hb=5
      sent = 0;
      while (sent < 256) begin
         len = $urandom_range(1, 4);
         if (len > 256 - sent) len = 256 - sent;
         burst_q.delete();
         for (int i = 0; i < len; i++) burst_q.push_back(8'($urandom));
         run_burst(5, -1, 0);
         sent += len;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // A few bursts at random half-bit lengths, including 0
      for (int j = 0; j < 12; j++) begin
         len = $urandom_range(1, 3);
         hbl = $urandom_range(0, 7);
         burst_q.delete();
         for (int i = 0; i < len; i++) burst_q.push_back(8'($urandom));
         run_burst(hbl, -1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
